// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: 16B memory messages and requester IDs.
package mem_arb_pkg;

  localparam int unsigned c_default_outstanding = 4;
  localparam int unsigned c_max_reqs            = 4;

  // Wide enough for the largest supported requester count.
  typedef logic [$clog2(c_max_reqs)-1:0] req_id_t;

  typedef struct packed {
    logic [2:0]   type_;
    logic [7:0]   opaque;
    logic [31:0]  addr;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_req_16B_t;

  typedef struct packed {
    logic [2:0]   type_;
    logic [7:0]   opaque;
    logic [1:0]   test;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_resp_16B_t;

endpackage

// File: rtl/mem_arb_id_fifo.sv
// In-order FIFO of requester IDs for outstanding memory requests; push and pop may share a cycle.
module mem_arb_id_fifo
  import mem_arb_pkg::*;
#(
  parameter int unsigned p_depth = c_default_outstanding
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  req_id_t                      push_id_i,
  input  logic                         pop_i,
  output req_id_t                      head_id_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(p_depth):0]     count_o
);

  localparam int unsigned c_ptr_w = $clog2(p_depth);
  localparam int unsigned c_cnt_w = c_ptr_w + 1;

  req_id_t              mem_q [p_depth];
  logic [c_ptr_w-1:0]   head_q, head_d;
  logic [c_ptr_w-1:0]   tail_q, tail_d;
  logic [c_cnt_w-1:0]   count_q, count_d;

  assign head_id_o = mem_q[head_q];
  assign full_o    = (count_q == c_cnt_w'(p_depth));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;

  // Next-state pointers and occupancy; depth is a power of two so pointers wrap naturally.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_i) begin
      tail_d = tail_q + c_ptr_w'(1);
    end else begin
      tail_d = tail_q;
    end
    if (pop_i) begin
      head_d = head_q + c_ptr_w'(1);
    end else begin
      head_d = head_q;
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + c_cnt_w'(1);
      2'b01:   count_d = count_q - c_cnt_w'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers and ID storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(p_depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push_i) begin
        mem_q[tail_q] <= push_id_i;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one 16B memory port among cache requesters; responses are
// steered back in order using the outstanding-ID FIFO.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned p_num_reqs        = 2,
  parameter int unsigned p_max_outstanding = c_default_outstanding
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  mem_req_16B_t  [p_num_reqs-1:0]         req_msg,
  input  logic          [p_num_reqs-1:0]         req_val,
  output logic          [p_num_reqs-1:0]         req_rdy,
  output mem_resp_16B_t [p_num_reqs-1:0]         resp_msg,
  output logic          [p_num_reqs-1:0]         resp_val,
  input  logic          [p_num_reqs-1:0]         resp_rdy,
  output mem_req_16B_t                           memreq_msg,
  output logic                                   memreq_val,
  input  logic                                   memreq_rdy,
  input  mem_resp_16B_t                          memresp_msg,
  input  logic                                   memresp_val,
  output logic                                   memresp_rdy,
  output logic [$clog2(p_max_outstanding):0]     outstanding,
  output logic                                   err_unexpected_resp
);

  req_id_t ptr_q, ptr_d;
  req_id_t grant_s;
  req_id_t head_id_s;
  logic    found_s;
  logic    full_s, empty_s;
  logic    req_fire_s, resp_fire_s;
  logic    err_q, err_d;

  // Round-robin search from the priority pointer with wrap-around.
  always_comb begin
    grant_s = ptr_q;
    found_s = 1'b0;
    for (int k = 0; k < int'(p_num_reqs); k++) begin
      for (int i = 0; i < int'(p_num_reqs); i++) begin
        if (!found_s && req_val[i] && ((int'(ptr_q) + k) % int'(p_num_reqs) == i)) begin
          grant_s = req_id_t'(i);
          found_s = 1'b1;
        end else begin
          found_s = found_s;
        end
      end
    end
  end

  // Request mux and per-lane handshakes; every val/rdy is held low while in reset.
  always_comb begin
    memreq_msg  = req_msg[0];
    memreq_val  = reset && (|req_val) && !full_s;
    memresp_rdy = 1'b0;
    for (int i = 0; i < int'(p_num_reqs); i++) begin
      resp_msg[i] = memresp_msg;
      req_rdy[i]  = reset && (grant_s == req_id_t'(i)) && memreq_rdy && !full_s;
      resp_val[i] = reset && memresp_val && !empty_s && (head_id_s == req_id_t'(i));
      if (grant_s == req_id_t'(i)) begin
        memreq_msg = req_msg[i];
      end else begin
        memreq_msg = memreq_msg;
      end
      if (reset && !empty_s && (head_id_s == req_id_t'(i))) begin
        memresp_rdy = resp_rdy[i];
      end else begin
        memresp_rdy = memresp_rdy;
      end
    end
  end

  assign req_fire_s  = memreq_val && memreq_rdy;
  assign resp_fire_s = memresp_val && memresp_rdy;
  assign err_unexpected_resp = err_q;

  // Pointer advances past the winner only when a request actually fires.
  always_comb begin
    ptr_d = ptr_q;
    if (req_fire_s) begin
      if (int'(grant_s) + 1 >= int'(p_num_reqs)) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_s + req_id_t'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
    err_d = err_q | (memresp_val & empty_s);
  end

  // Priority pointer and sticky unexpected-response flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
      err_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      err_q <= err_d;
    end
  end

  mem_arb_id_fifo #(
    .p_depth (p_max_outstanding)
  ) u_id_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push_i    (req_fire_s),
    .push_id_i (grant_s),
    .pop_i     (resp_fire_s),
    .head_id_o (head_id_s),
    .full_o    (full_s),
    .empty_o   (empty_s),
    .count_o   (outstanding)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with two requesters and depth 4.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic                clk;
  logic                reset;
  mem_req_16B_t  [1:0] req_msg;
  logic          [1:0] req_val;
  logic          [1:0] req_rdy;
  mem_resp_16B_t [1:0] resp_msg;
  logic          [1:0] resp_val;
  logic          [1:0] resp_rdy;
  mem_req_16B_t        memreq_msg;
  logic                memreq_val;
  logic                memreq_rdy;
  mem_resp_16B_t       memresp_msg;
  logic                memresp_val;
  logic                memresp_rdy;
  logic [2:0]          outstanding;
  logic                err_unexpected_resp;

  int n_run;
  int n_fail;

  mem_port_arbiter #(.p_num_reqs(2), .p_max_outstanding(4)) dut (
    .clk(clk), .reset(reset),
    .req_msg(req_msg), .req_val(req_val), .req_rdy(req_rdy),
    .resp_msg(resp_msg), .resp_val(resp_val), .resp_rdy(resp_rdy),
    .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
    .memresp_msg(memresp_msg), .memresp_val(memresp_val), .memresp_rdy(memresp_rdy),
    .outstanding(outstanding), .err_unexpected_resp(err_unexpected_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic mem_req_16B_t mk_req(input logic [7:0] op, input logic [31:0] addr);
    mem_req_16B_t m;
    m.type_ = 3'd0; m.opaque = op; m.addr = addr; m.len = 4'd0; m.data = 128'd0;
    return m;
  endfunction

  function automatic mem_resp_16B_t mk_resp(input logic [7:0] op, input logic [127:0] data);
    mem_resp_16B_t m;
    m.type_ = 3'd0; m.opaque = op; m.test = 2'd0; m.len = 4'd0; m.data = data;
    return m;
  endfunction

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset;
    reset = 1'b0;
    #3;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    reset = 1'b0; req_val = 2'b11; memreq_rdy = 1'b1; memresp_val = 1'b1; resp_rdy = 2'b11;
    req_msg[0] = mk_req(8'h00, 32'h0); req_msg[1] = mk_req(8'h01, 32'h0);
    memresp_msg = mk_resp(8'h00, 128'd0);
    #2;
    n_run++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding); end
    n_run++; if (memreq_val !== 1'b0) begin n_fail++; $display("FAIL reset_memreq_val: got %b expected 0", memreq_val); end
    n_run++; if (req_rdy !== 2'b00) begin n_fail++; $display("FAIL reset_req_rdy: got %b expected 00", req_rdy); end
    n_run++; if (resp_val !== 2'b00 || memresp_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_resp: got val %b rdy %b expected 00 0", resp_val, memresp_rdy); end
    n_run++; if (err_unexpected_resp !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err_unexpected_resp); end
    req_val = 2'b00; memresp_val = 1'b0;
    #10;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single;
    mem_req_16B_t  rq;
    mem_resp_16B_t rs;
    rq = mk_req(8'h05, 32'h0000_1000);
    rs = mk_resp(8'h05, 128'hDEADBEEF_00000000_00000000_00000000);
    req_msg[0] = rq; req_val = 2'b01; memreq_rdy = 1'b1; resp_rdy = 2'b11;
    #1;
    n_run++; if (memreq_msg !== rq) begin n_fail++; $display("FAIL single_memreq_msg: got %h expected %h", memreq_msg, rq); end
    n_run++; if (memreq_val !== 1'b1 || req_rdy !== 2'b01) begin n_fail++; $display("FAIL single_handshake: got val %b rdy %b expected 1 01", memreq_val, req_rdy); end
    n_run++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL single_out0: got %0d expected 0", outstanding); end
    tick();
    n_run++; if (outstanding !== 3'd1) begin n_fail++; $display("FAIL single_out1: got %0d expected 1", outstanding); end
    req_val = 2'b00; memresp_msg = rs; memresp_val = 1'b1;
    #1;
    n_run++; if (resp_val !== 2'b01) begin n_fail++; $display("FAIL single_resp_val: got %b expected 01", resp_val); end
    n_run++; if (memresp_rdy !== 1'b1) begin n_fail++; $display("FAIL single_memresp_rdy: got %b expected 1", memresp_rdy); end
    n_run++; if (resp_msg[0] !== rs || resp_msg[1] !== rs) begin n_fail++; $display("FAIL single_resp_msg: got %h expected %h", resp_msg[0], rs); end
    tick();
    memresp_val = 1'b0;
    n_run++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL single_out_end: got %0d expected 0", outstanding); end
  endtask

  task automatic test_fairness;
    mem_req_16B_t r0, r1;
    apply_reset();
    r0 = mk_req(8'h10, 32'h0000_2000); r1 = mk_req(8'h11, 32'h0000_3000);
    req_msg[0] = r0; req_msg[1] = r1; req_val = 2'b11; memreq_rdy = 1'b1; resp_rdy = 2'b11;
    for (int k = 0; k < 7; k++) begin
      memresp_val = (k > 0);
      memresp_msg = mk_resp(8'h20 + 8'(k), 128'd0);
      if (k == 6) req_val = 2'b00;
      #1;
      if (k < 6) begin
        n_run++; if (memreq_msg !== ((k % 2 == 1) ? r1 : r0)) begin n_fail++; $display("FAIL fair_grant_%0d: got opaque %h expected lane %0d", k, memreq_msg.opaque, k % 2); end
        n_run++; if (req_rdy !== ((k % 2 == 1) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL fair_req_rdy_%0d: got %b", k, req_rdy); end
      end
      if (k > 0) begin
        n_run++; if (resp_val !== (((k - 1) % 2 == 1) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL fair_resp_%0d: got %b expected lane %0d", k, resp_val, (k - 1) % 2); end
      end
      tick();
    end
    memresp_val = 1'b0;
    n_run++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL fair_drain: got %0d expected 0", outstanding); end
  endtask

  task automatic test_full;
    req_val = 2'b01; memresp_val = 1'b0; memreq_rdy = 1'b1; resp_rdy = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_run++; if (req_rdy !== 2'b01) begin n_fail++; $display("FAIL full_fill_%0d: got rdy %b expected 01", k, req_rdy); end
      tick();
    end
    #1;
    n_run++; if (outstanding !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d expected 4", outstanding); end
    n_run++; if (memreq_val !== 1'b0 || req_rdy !== 2'b00) begin n_fail++; $display("FAIL full_block: got val %b rdy %b expected 0 00", memreq_val, req_rdy); end
    memresp_val = 1'b1;
    #1;
    n_run++; if (memresp_rdy !== 1'b1 || memreq_val !== 1'b0 || req_rdy !== 2'b00) begin n_fail++; $display("FAIL full_pop_cycle: got mrdy %b val %b rdy %b expected 1 0 00", memresp_rdy, memreq_val, req_rdy); end
    tick();
    memresp_val = 1'b0;
    #1;
    n_run++; if (outstanding !== 3'd3 || memreq_val !== 1'b1 || req_rdy !== 2'b01) begin n_fail++; $display("FAIL full_reaccept: got cnt %0d val %b rdy %b expected 3 1 01", outstanding, memreq_val, req_rdy); end
    tick();
    n_run++; if (outstanding !== 3'd4) begin n_fail++; $display("FAIL full_refill: got %0d expected 4", outstanding); end
    req_val = 2'b00; memresp_val = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_run++; if (resp_val !== 2'b01) begin n_fail++; $display("FAIL full_drain_%0d: got %b expected 01", k, resp_val); end
      tick();
    end
    memresp_val = 1'b0;
  endtask

  task automatic test_backpressure;
    mem_req_16B_t r0, r1;
    apply_reset();
    r0 = mk_req(8'hA0, 32'h0000_4000); r1 = mk_req(8'hB1, 32'h0000_5000);
    req_msg[0] = r0; req_msg[1] = r1; req_val = 2'b11; memreq_rdy = 1'b0; resp_rdy = 2'b11;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_run++; if (memreq_val !== 1'b1 || memreq_msg !== r0 || req_rdy !== 2'b00) begin n_fail++; $display("FAIL bp_stall_%0d: got val %b opaque %h rdy %b expected 1 a0 00", k, memreq_val, memreq_msg.opaque, req_rdy); end
      tick();
    end
    memreq_rdy = 1'b1;
    #1;
    n_run++; if (req_rdy !== 2'b01 || outstanding !== 3'd0) begin n_fail++; $display("FAIL bp_release: got rdy %b cnt %0d expected 01 0", req_rdy, outstanding); end
    tick();
    n_run++; if (memreq_msg !== r1 || outstanding !== 3'd1) begin n_fail++; $display("FAIL bp_next_grant: got opaque %h cnt %0d expected b1 1", memreq_msg.opaque, outstanding); end
    tick();
    req_val = 2'b00; memresp_val = 1'b1; resp_rdy = 2'b10;
    #1;
    n_run++; if (memresp_rdy !== 1'b0 || resp_val !== 2'b01) begin n_fail++; $display("FAIL bp_resp_hold: got mrdy %b val %b expected 0 01", memresp_rdy, resp_val); end
    tick();
    n_run++; if (outstanding !== 3'd2) begin n_fail++; $display("FAIL bp_no_pop: got %0d expected 2", outstanding); end
    resp_rdy = 2'b11;
    #1;
    n_run++; if (memresp_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_resp_go: got %b expected 1", memresp_rdy); end
    tick();
    tick();
    memresp_val = 1'b0;
    n_run++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL bp_drain: got %0d expected 0", outstanding); end
  endtask

  task automatic test_push_pop;
    req_val = 2'b11; memreq_rdy = 1'b1; resp_rdy = 2'b11; memresp_val = 1'b0;
    tick();
    tick();
    n_run++; if (outstanding !== 3'd2) begin n_fail++; $display("FAIL pp_prefill: got %0d expected 2", outstanding); end
    req_val = 2'b01; memresp_val = 1'b1;
    #1;
    n_run++; if (resp_val !== 2'b01 || req_rdy !== 2'b01) begin n_fail++; $display("FAIL pp_a: got val %b rdy %b expected 01 01", resp_val, req_rdy); end
    tick();
    n_run++; if (outstanding !== 3'd2) begin n_fail++; $display("FAIL pp_a_count: got %0d expected 2", outstanding); end
    req_val = 2'b10;
    #1;
    n_run++; if (resp_val !== 2'b10 || req_rdy !== 2'b10) begin n_fail++; $display("FAIL pp_b: got val %b rdy %b expected 10 10", resp_val, req_rdy); end
    tick();
    n_run++; if (outstanding !== 3'd2) begin n_fail++; $display("FAIL pp_b_count: got %0d expected 2", outstanding); end
    req_val = 2'b00;
    #1;
    n_run++; if (resp_val !== 2'b01) begin n_fail++; $display("FAIL pp_wrap_head0: got %b expected 01", resp_val); end
    tick();
    #1;
    n_run++; if (resp_val !== 2'b10 || outstanding !== 3'd1) begin n_fail++; $display("FAIL pp_wrap_head1: got %b cnt %0d expected 10 1", resp_val, outstanding); end
    tick();
    memresp_val = 1'b0;
    n_run++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL pp_drain: got %0d expected 0", outstanding); end
  endtask

  task automatic test_error_and_reset;
    memresp_val = 1'b1; resp_rdy = 2'b11; req_val = 2'b00;
    #1;
    n_run++; if (memresp_rdy !== 1'b0 || resp_val !== 2'b00 || err_unexpected_resp !== 1'b0) begin n_fail++; $display("FAIL err_pre: got mrdy %b val %b err %b expected 0 00 0", memresp_rdy, resp_val, err_unexpected_resp); end
    tick();
    memresp_val = 1'b0;
    n_run++; if (err_unexpected_resp !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b expected 1", err_unexpected_resp); end
    tick();
    n_run++; if (err_unexpected_resp !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", err_unexpected_resp); end
    req_val = 2'b11; memreq_rdy = 1'b1;
    tick();
    tick();
    n_run++; if (outstanding !== 3'd2) begin n_fail++; $display("FAIL rst_burst: got %0d expected 2", outstanding); end
    memresp_val = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    n_run++; if (outstanding !== 3'd0 || err_unexpected_resp !== 1'b0) begin n_fail++; $display("FAIL rst_state: got cnt %0d err %b expected 0 0", outstanding, err_unexpected_resp); end
    n_run++; if (memreq_val !== 1'b0 || req_rdy !== 2'b00 || resp_val !== 2'b00 || memresp_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_outputs: got %b %b %b %b expected all 0", memreq_val, req_rdy, resp_val, memresp_rdy); end
    req_val = 2'b00; memresp_val = 1'b0;
    #5;
    reset = 1'b1;
    tick();
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    test_reset();
    test_single();
    test_fairness();
    test_full();
    test_backpressure();
    test_push_pop();
    test_error_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 16B memory port among p_num_reqs blocking-cache refill/evict ports (e.g. icache = 0, dcache = 1).
- Uses round-robin arbitration on memory requests. Responses are steered back to the issuing requester through an in-order outstanding-ID FIFO.
- Sits between the cache memreq/memresp interfaces and the test memory or next level.
- Message contents, including opaque, pass through unmodified.

Parameters:
- p_num_reqs, 2, number of requester ports (2..4).
- p_max_outstanding, 4, depth of the outstanding-ID FIFO; power of two, at least 2.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req_msg  in  p_num_reqs x mem_req_16B_t  per-requester memory request.
- req_val  in  p_num_reqs  request valid.
- req_rdy  out  p_num_reqs  request ready.
- resp_msg  out  p_num_reqs x mem_resp_16B_t  per-requester response; every lane carries memresp_msg.
- resp_val  out  p_num_reqs  response valid.
- resp_rdy  in  p_num_reqs  response ready.
- memreq_msg  out  mem_req_16B_t  request to memory.
- memreq_val  out  1  memory request valid.
- memreq_rdy  in  1  memory request ready.
- memresp_msg  in  mem_resp_16B_t  memory response.
- memresp_val  in  1  memory response valid.
- memresp_rdy  out  1  memory response ready.
- outstanding  out  $clog2(p_max_outstanding)+1  current FIFO occupancy.
- err_unexpected_resp  out  1  sticky error flag.

Behaviour:
- Reset (reset == 0, asynchronous):
  - priority pointer = 0; FIFO head = tail = count = 0; err_unexpected_resp = 0.
  - While reset is asserted, all val/rdy outputs are forced to 0.
- Request path (combinational, zero added latency):
  - The grant goes to the first requester with req_val = 1, searching from the priority pointer upward with wrap-around.
  - memreq_msg = req_msg[grant].
  - memreq_val = any(req_val) && !full.
  - req_rdy[i] = (i == grant) && memreq_rdy && !full.
  - A request fires when memreq_val && memreq_rdy.
- On request fire:
  - Push the grant ID into the FIFO.
  - Priority pointer <= (grant + 1) mod p_num_reqs.
  - No fire means the pointer holds, so a stalled grant is sticky: the grant cannot change while memreq_val = 1 and memreq_rdy = 0, provided the granted requester holds val.
- Full condition: count == p_max_outstanding.
  - memreq_val = 0 and all req_rdy = 0.
  - This holds even if a pop happens in the same cycle; new requests accept from the next cycle.
- Response path (in-order memory assumed): let head = FIFO[head].
  - resp_val[i] = memresp_val && !empty && (i == head).
  - memresp_rdy = !empty && resp_rdy[head].
  - A response fires when memresp_val && memresp_rdy; it pops the FIFO.
- Simultaneous push and pop when not full: count unchanged, head and tail both advance.
- Pointer wrap: head and tail wrap modulo p_max_outstanding.
- Unexpected response: memresp_val = 1 while empty.
  - memresp_rdy = 0.
  - err_unexpected_resp <= 1, sticky until reset.
- Reset mid-transaction: the FIFO is discarded. In-flight memory responses after reset count as unexpected; the environment must drain memory.
- Requester obligations: req_msg must be held stable while req_val = 1 and not accepted. resp_rdy may toggle freely.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the requester ID typedef: logic [$clog2(p_num_reqs)-1:0];
  - the localparam for default depth.
- mem_req_16B_t and mem_resp_16B_t come from the existing mem-msgs definitions.
- Sub-module mem_arb_id_fifo: a synchronous FIFO with async active-low reset, push/pop/full/empty/count, and same-cycle push+pop.
- Round-robin grant logic stays inline.

Test Plan:
- Single requester:
  - Stimulus: req 0 issues read addr 0x00001000, opaque 0x05; memory returns data 0xDEADBEEF_…_0 one cycle later.
  - Required: memreq_msg equals the req_msg bit-for-bit; resp_val[0] = 1 and resp_val[1] = 0; outstanding goes 0 → 1 → 0.
- Fairness:
  - Stimulus: both requesters hold req_val = 1 for 6 grants, memreq_rdy = 1.
  - Required: grants alternate 0, 1, 0, 1, 0, 1; responses return in that order to the matching lanes.
- Full:
  - Stimulus: memory holds memresp_val = 0 while 4 requests are accepted.
  - Required: outstanding = 4, memreq_val = 0, req_rdy = 0.
  - Then a response pops: no accept that cycle, accept the next cycle.
- Backpressure:
  - Stimulus: memreq_rdy = 0 for 3 cycles with both requesters valid.
  - Required: grant and memreq_msg stay stable; the pointer does not move.
  - Stimulus: resp_rdy[head] = 0.
  - Required: memresp_rdy = 0 and the FIFO does not pop.
- Push and pop in the same cycle:
  - Stimulus: at count = 2, one request fires and one response fires in the same cycle.
  - Required: count stays 2, and the head ID routes correctly after head/tail wrap past index 3.
- Error and reset:
  - Stimulus: memresp_val = 1 with the FIFO empty.
  - Required: memresp_rdy = 0 and err_unexpected_resp = 1 from the next edge.
  - Stimulus: reset is driven low asynchronously mid-burst.
  - Required: immediately outstanding = 0, all val/rdy = 0, err_unexpected_resp = 0.
